// File: rtl/alarm_pkg.sv
// Shared constants and helpers for the alarm scheduler: FSM encoding,
// time limits, slot ids and id <-> one-hot conversion.
package alarm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RING = 1'b1
  } state_t;

  localparam logic [4:0] MAX_HOUR = 5'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_SEC  = 6'd59;

  localparam logic [1:0] NO_ALARM = 2'd0;
  localparam logic [1:0] ALARM_1  = 2'd1;
  localparam logic [1:0] ALARM_2  = 2'd2;
  localparam logic [1:0] ALARM_3  = 2'd3;

  function automatic logic [2:0] id_mask(input logic [1:0] id);
    case (id)
      ALARM_1: id_mask = 3'b001;
      ALARM_2: id_mask = 3'b010;
      ALARM_3: id_mask = 3'b100;
      default: id_mask = 3'b000;
    endcase
  endfunction

  // Fixed priority: lowest slot index wins.
  function automatic logic [1:0] lowest_id(input logic [2:0] p);
    if (p[0])      lowest_id = ALARM_1;
    else if (p[1]) lowest_id = ALARM_2;
    else if (p[2]) lowest_id = ALARM_3;
    else           lowest_id = NO_ALARM;
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: range-checked time storage, armed flag and the
// equality compare against the running clock.
module alarm_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       clear,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       armed,
  output logic       match,
  output logic       load_err,
  output logic       loaded
);
  import alarm_pkg::*;

  logic [4:0] hour_reg;
  logic [5:0] min_reg;
  logic [5:0] sec_reg;
  logic       armed_reg;
  logic       in_range;

  assign in_range = (hour <= MAX_HOUR) && (min <= MAX_MIN) && (sec <= MAX_SEC);
  // A disarm in the same cycle overrides the load.
  assign loaded   = set & in_range & ~clear;
  assign load_err = set & ~in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_reg  <= '0;
      min_reg   <= '0;
      sec_reg   <= '0;
      armed_reg <= 1'b0;
    end else if (clear) begin
      armed_reg <= 1'b0;
    end else if (loaded) begin
      hour_reg  <= hour;
      min_reg   <= min;
      sec_reg   <= sec;
      armed_reg <= 1'b1;
    end
  end

  assign armed = armed_reg;
  assign match = armed_reg && (hour_reg == cur_hour) && (min_reg == cur_min) &&
                 (sec_reg == cur_sec);

endmodule

// File: rtl/alarm_scheduler.sv
// Owns the three alarm slots, queues their matches, and drives the single
// buzzer with stop, snooze and auto-timeout handling.
module alarm_scheduler #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] hour1,
  input  logic [4:0] hour2,
  input  logic [4:0] hour3,
  input  logic [5:0] min1,
  input  logic [5:0] min2,
  input  logic [5:0] min3,
  input  logic [5:0] sec1,
  input  logic [5:0] sec2,
  input  logic [5:0] sec3,
  input  logic       set1,
  input  logic       set2,
  input  logic       set3,
  input  logic [2:0] disarm,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       ring_out,
  output logic       ringing,
  output logic [1:0] active_id,
  output logic [2:0] armed,
  output logic       snoozed,
  output logic       set_err
);
  import alarm_pkg::*;

  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
  localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);

  logic [4:0] hour_arr [3];
  logic [5:0] min_arr  [3];
  logic [5:0] sec_arr  [3];
  logic [2:0] set_vec, match, load_err, loaded;

  assign hour_arr = '{hour1, hour2, hour3};
  assign min_arr  = '{min1, min2, min3};
  assign sec_arr  = '{sec1, sec2, sec3};
  assign set_vec  = {set3, set2, set1};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
      alarm_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .set      (set_vec[gi]),
        .clear    (disarm[gi]),
        .hour     (hour_arr[gi]),
        .min      (min_arr[gi]),
        .sec      (sec_arr[gi]),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .armed    (armed[gi]),
        .match    (match[gi]),
        .load_err (load_err[gi]),
        .loaded   (loaded[gi])
      );
    end
  endgenerate

  state_t              state_reg;
  logic [1:0]          active_reg;
  logic [RING_W-1:0]   ring_cnt_reg;
  logic                ring_out_reg;  // doubles as the beep phase while ringing
  logic [2:0]          pending_reg, pend_next, pend_avail;
  logic                snz_valid_reg, snz_valid_next;
  logic [SNZ_W-1:0]    snz_cnt_reg, snz_cnt_next;
  logic [1:0]          snz_id_reg, snz_id_next;
  logic                set_err_reg;
  logic [2:0]          kill, act_mask;
  logic                end_by_slot, stop_go, snz_go, auto_go, exit_go;

  always_comb begin
    kill        = disarm | loaded;
    act_mask    = (state_reg == RING) ? id_mask(active_reg) : 3'b000;
    end_by_slot = |(kill & act_mask);
    stop_go     = (state_reg == RING) & stop_btn;
    snz_go      = (state_reg == RING) & snooze_btn & ~stop_btn & ~end_by_slot;
    auto_go     = (state_reg == RING) & tick_1hz & (ring_cnt_reg == RING_LAST);
    exit_go     = end_by_slot | stop_go | snz_go | auto_go;

    pend_next      = pending_reg | (tick_1hz ? match : 3'b000);
    snz_valid_next = snz_valid_reg;
    snz_cnt_next   = snz_cnt_reg;
    snz_id_next    = snz_id_reg;
    if (snz_go) begin
      snz_valid_next = 1'b1;
      snz_cnt_next   = SNZ_LOAD;
      snz_id_next    = active_reg;
    end else if (snz_valid_reg) begin
      if (|(kill & id_mask(snz_id_reg))) begin
        snz_valid_next = 1'b0;
      end else if (tick_1hz) begin
        if (snz_cnt_reg == SNZ_ONE) begin
          pend_next      = pend_next | id_mask(snz_id_reg);
          snz_valid_next = 1'b0;
          snz_cnt_next   = '0;
        end else begin
          snz_cnt_next = snz_cnt_reg - 1'b1;
        end
      end
    end
    pend_next  = pend_next & ~kill & ~(exit_go ? act_mask : 3'b000);
    pend_avail = pending_reg & ~kill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      active_reg    <= NO_ALARM;
      ring_cnt_reg  <= '0;
      ring_out_reg  <= 1'b0;
      pending_reg   <= '0;
      snz_valid_reg <= 1'b0;
      snz_cnt_reg   <= '0;
      snz_id_reg    <= NO_ALARM;
      set_err_reg   <= 1'b0;
    end else begin
      pending_reg   <= pend_next;
      snz_valid_reg <= snz_valid_next;
      snz_cnt_reg   <= snz_cnt_next;
      snz_id_reg    <= snz_id_next;
      set_err_reg   <= |load_err;
      case (state_reg)
        IDLE: begin
          if (|pend_avail) begin
            state_reg    <= RING;
            active_reg   <= lowest_id(pend_avail);
            ring_cnt_reg <= '0;
            ring_out_reg <= 1'b1;
          end
        end
        RING: begin
          if (exit_go) begin
            state_reg    <= IDLE;
            active_reg   <= NO_ALARM;
            ring_cnt_reg <= '0;
            ring_out_reg <= 1'b0;
          end else if (tick_1hz) begin
            ring_cnt_reg <= ring_cnt_reg + 1'b1;
            ring_out_reg <= ~ring_out_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ring_out  = ring_out_reg;
  assign ringing   = (state_reg == RING);
  assign active_id = active_reg;
  assign snoozed   = snz_valid_reg;
  assign set_err   = set_err_reg;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed test-plan steps followed by a randomized phase, all checked
// cycle by cycle against a rule-level reference model.
module tb_alarm_scheduler;

  localparam int RING_SECS   = 60;
  localparam int SNOOZE_SECS = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic [4:0] hour1 = '0, hour2 = '0, hour3 = '0;
  logic [5:0] min1 = '0, min2 = '0, min3 = '0;
  logic [5:0] sec1 = '0, sec2 = '0, sec3 = '0;
  logic       set1 = 1'b0, set2 = 1'b0, set3 = 1'b0;
  logic [2:0] disarm = '0;
  logic       stop_btn = 1'b0, snooze_btn = 1'b0;
  logic       ring_out, ringing, snoozed, set_err;
  logic [1:0] active_id;
  logic [2:0] armed;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  alarm_scheduler #(.RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .hour1(hour1), .hour2(hour2), .hour3(hour3),
    .min1(min1), .min2(min2), .min3(min3),
    .sec1(sec1), .sec2(sec2), .sec3(sec3),
    .set1(set1), .set2(set2), .set3(set3),
    .disarm(disarm), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .ring_out(ring_out), .ringing(ringing), .active_id(active_id),
    .armed(armed), .snoozed(snoozed), .set_err(set_err)
  );

  always #5 clk = ~clk;

  // Reference model state, in plain seconds/ids.
  int       m_h[3], m_m[3], m_s[3];
  bit [2:0] m_armed, m_pend;
  bit       m_ring, m_snz, m_err;
  int       m_id, m_el, m_snz_left, m_snz_id;

  task automatic model_update();
    int hh[3], mm[3], ss[3];
    logic [2:0] setv, load_ok, kill, match, p, avail;
    bit err, ok, end_slot, do_stop, do_snz, do_auto, leave;
    int a;
    if (rst) begin
      m_armed = 0; m_pend = 0; m_ring = 0; m_id = 0; m_el = 0;
      m_snz = 0; m_snz_left = 0; m_snz_id = 0; m_err = 0;
      for (int i = 0; i < 3; i++) begin m_h[i] = 0; m_m[i] = 0; m_s[i] = 0; end
      return;
    end
    hh = '{int'(hour1), int'(hour2), int'(hour3)};
    mm = '{int'(min1), int'(min2), int'(min3)};
    ss = '{int'(sec1), int'(sec2), int'(sec3)};
    setv = {set3, set2, set1};
    err = 0; load_ok = 0; match = 0;
    for (int i = 0; i < 3; i++) begin
      ok = hh[i] <= 23 && mm[i] <= 59 && ss[i] <= 59;
      load_ok[i] = setv[i] && ok && !disarm[i];
      if (setv[i] && !ok) err = 1;
      match[i] = m_armed[i] && m_h[i] == int'(cur_hour) && m_m[i] == int'(cur_min) &&
                 m_s[i] == int'(cur_sec);
    end
    kill     = disarm | load_ok;
    a        = m_ring ? m_id - 1 : 0;
    end_slot = m_ring && kill[a];
    do_stop  = m_ring && stop_btn;
    do_snz   = m_ring && snooze_btn && !stop_btn && !end_slot;
    do_auto  = m_ring && tick_1hz && (m_el + 1 == RING_SECS);
    leave    = end_slot || do_stop || do_snz || do_auto;
    p = m_pend;
    if (tick_1hz) p = p | match;
    if (do_snz) begin
      m_snz = 1; m_snz_left = SNOOZE_SECS; m_snz_id = m_id;
    end else if (m_snz) begin
      if (kill[m_snz_id-1]) m_snz = 0;
      else if (tick_1hz) begin
        m_snz_left--;
        if (m_snz_left == 0) begin p[m_snz_id-1] = 1'b1; m_snz = 0; end
      end
    end
    p = p & ~kill;
    if (leave) p[a] = 1'b0;
    avail = m_pend & ~kill;
    if (!m_ring) begin
      if (avail != 0) begin
        m_ring = 1; m_el = 0;
        m_id = avail[0] ? 1 : (avail[1] ? 2 : 3);
      end
    end else if (leave) begin
      m_ring = 0; m_id = 0; m_el = 0;
    end else if (tick_1hz) begin
      m_el++;
    end
    m_pend = p;
    m_err  = err;
    for (int i = 0; i < 3; i++) begin
      if (disarm[i]) m_armed[i] = 0;
      else if (load_ok[i]) begin
        m_h[i] = hh[i]; m_m[i] = mm[i]; m_s[i] = ss[i]; m_armed[i] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: model steps with the edge, outputs compared 1 time unit later.
  task automatic cyc();
    logic [8:0] exp_v;
    @(posedge clk);
    model_update();
    #1;
    exp_v = {m_ring && (m_el % 2 == 0), m_ring, 2'(m_id), m_armed, m_snz, m_err};
    chk("model", {ring_out, ringing, active_id, armed, snoozed, set_err}, exp_v);
    set1 = 0; set2 = 0; set3 = 0; disarm = '0;
    stop_btn = 0; snooze_btn = 0; tick_1hz = 0;
  endtask

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  task automatic tick_at(input int t);
    cur_hour = 5'(t / 3600);
    cur_min  = 6'((t / 60) % 60);
    cur_sec  = 6'(t % 60);
    tick_1hz = 1;
    cyc();
  endtask

  function automatic logic [4:0] rnd_h();
    return ($urandom % 8 == 0) ? 5'(24 + $urandom % 8) : 5'($urandom % 2);
  endfunction

  function automatic logic [5:0] rnd_ms(input int span);
    return ($urandom % 10 == 0) ? 6'(60 + $urandom % 4) : 6'($urandom % span);
  endfunction

  initial begin
    int t;
    // Reset
    rst = 1; cyc(); cyc();
    chk("reset_outputs", {ring_out, ringing, active_id, armed, snoozed, set_err}, 9'd0);
    rst = 0;

    // Alarm 2 at 07:30:05, auto-stop after RING_SECS ticks
    set2 = 1; hour2 = 7; min2 = 30; sec2 = 5; cyc();
    chk("load2_armed", armed, 3'b010);
    tick_at(hms(7, 30, 4)); cyc();
    tick_at(hms(7, 30, 5));
    chk("match_t1_not_ringing", ringing, 1'b0);
    cyc();
    chk("match_t2_ringing", ringing, 1'b1);
    chk("match_t2_id", active_id, 2'd2);
    chk("match_t2_ring_out", ring_out, 1'b1);
    t = hms(7, 30, 5);
    for (int k = 1; k <= RING_SECS; k++) begin
      t++;
      tick_at(t);
      if (k == 2) chk("beep_k2", ring_out, 1'b1);
      if (k == 3) chk("beep_k3", ring_out, 1'b0);
      if (k == RING_SECS - 1) chk("still_ringing_59", ringing, 1'b1);
      if (k == RING_SECS) chk("auto_stop", ringing, 1'b0);
      cyc();
    end
    chk("armed2_after_ring", armed[1], 1'b1);

    // Alarms 1 and 3 simultaneously: 1 first, 3 after one idle cycle
    set1 = 1; hour1 = 12; min1 = 0; sec1 = 0;
    set3 = 1; hour3 = 12; min3 = 0; sec3 = 0;
    cyc();
    tick_at(hms(12, 0, 0)); cyc();
    chk("dual_first_id", active_id, 2'd1);
    stop_btn = 1; cyc();
    chk("dual_stop_idle", {ringing, active_id}, 3'b000);
    cyc();
    chk("dual_second_id", {ringing, active_id}, 3'b111);
    stop_btn = 1; cyc();

    // Snooze alarm 1 and let it come back
    disarm = 3'b100; cyc();
    tick_at(hms(12, 0, 0)); cyc();
    chk("snz_ring_id", active_id, 2'd1);
    t = hms(12, 0, 0);
    for (int k = 0; k < 3; k++) begin t++; tick_at(t); cyc(); end
    snooze_btn = 1; cyc();
    chk("snz_idle", {ringing, snoozed}, 2'b01);
    for (int k = 1; k < SNOOZE_SECS; k++) begin t++; tick_at(t); cyc(); end
    chk("snz_still_waiting", {ringing, snoozed}, 2'b01);
    t++; tick_at(t);
    chk("snz_expired", snoozed, 1'b0);
    cyc();
    chk("snz_rering", {ringing, active_id}, 3'b101);
    stop_btn = 1; cyc();

    // Range check on load
    set3 = 1; hour3 = 24; min3 = 0; sec3 = 0; cyc();
    chk("bad_load_err", set_err, 1'b1);
    chk("bad_load_armed3", armed[2], 1'b0);
    cyc();
    chk("set_err_one_cycle", set_err, 1'b0);
    set3 = 1; hour3 = 23; min3 = 59; sec3 = 59; cyc();
    chk("edge_load_armed3", armed[2], 1'b1);
    chk("edge_load_no_err", set_err, 1'b0);

    // Disarm the ringing slot; stop beats snooze
    set2 = 1; hour2 = 1; min2 = 0; sec2 = 0; cyc();
    tick_at(hms(1, 0, 0)); cyc();
    chk("slot2_ringing", active_id, 2'd2);
    disarm = 3'b010; cyc();
    chk("disarm_ringing", {ringing, armed[1]}, 2'b00);
    tick_at(hms(12, 0, 0)); cyc();
    stop_btn = 1; snooze_btn = 1; cyc();
    chk("stop_beats_snooze", {ringing, snoozed}, 2'b00);

    // Reset while ringing and snoozed
    tick_at(hms(12, 0, 0)); cyc();
    snooze_btn = 1; cyc();
    tick_at(hms(23, 59, 59)); cyc();
    chk("pre_reset_state", {ringing, active_id, snoozed}, 4'b1111);
    rst = 1; cyc();
    chk("reset_mid_ring", {ring_out, ringing, active_id, armed, snoozed, set_err}, 9'd0);
    rst = 0;
    tick_at(hms(23, 59, 59)); cyc();
    chk("no_ring_after_reset", ringing, 1'b0);

    // Randomized phase over a tiny time space so matches are frequent
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 400 == 0);
      if ($urandom % 2 == 0) begin
        tick_1hz = 1;
        cur_hour = 5'($urandom % 2); cur_min = 6'($urandom % 2); cur_sec = 6'($urandom % 3);
      end
      if ($urandom % 16 == 0) begin set1 = 1; hour1 = rnd_h(); min1 = rnd_ms(2); sec1 = rnd_ms(3); end
      if ($urandom % 16 == 0) begin set2 = 1; hour2 = rnd_h(); min2 = rnd_ms(2); sec2 = rnd_ms(3); end
      if ($urandom % 16 == 0) begin set3 = 1; hour3 = rnd_h(); min3 = rnd_ms(2); sec3 = rnd_ms(3); end
      for (int i = 0; i < 3; i++) if ($urandom % 40 == 0) disarm[i] = 1'b1;
      stop_btn   = ($urandom % 30 == 0);
      snooze_btn = ($urandom % 20 == 0);
      cyc();
    end
    rst = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Controller downstream of the UART alarm parser; owns the three alarm slots.
- Latches validated alarm times on the parser's set pulses and compares them with the running clock once per second.
- Arbitrates simultaneous or overlapping matches onto the single buzzer.
- Handles stop, snooze and auto-timeout. Alarms are daily: they stay armed after ringing until explicitly disarmed.

Parameters:
- RING_SECS, 60, ticks an alarm rings before auto-stop.
- SNOOZE_SECS, 300, ticks from snooze to re-ring.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_1hz  in  1  one-cycle pulse; cur_* already hold the new second in that cycle
- cur_hour  in  5  current hour, binary 0-23
- cur_min  in  6  current minute, binary 0-59
- cur_sec  in  6  current second, binary 0-59
- hour1/hour2/hour3  in  5 each  alarm hours from parser
- min1/min2/min3, sec1/sec2/sec3  in  6 each  alarm minutes/seconds from parser
- set1/set2/set3  in  1 each  one-cycle load strobes from parser
- disarm  in  3  one-cycle pulse per slot; bit0 = alarm 1
- stop_btn  in  1  debounced one-cycle pulse
- snooze_btn  in  1  debounced one-cycle pulse
- ring_out  out  1  buzzer enable (1 s on / 1 s off)
- ringing  out  1  state == RING
- active_id  out  2  ringing alarm, 1-3; 0 when idle
- armed  out  3  per-slot armed flags
- snoozed  out  1  snooze slot occupied
- set_err  out  1  one-cycle pulse: rejected load

Behaviour:
- Reset: all outputs 0, slot times 0, armed=0, pending=0, snooze slot empty, state IDLE. Reset mid-ring silences the buzzer on the next edge.
- Load: setN with hour≤23, min≤59, sec≤59 stores the time and sets armed[N]. An out-of-range load leaves the slot unchanged and pulses set_err. A load also clears pending[N].
- A reload of the snoozed slot cancels the snooze. A reload of the ringing slot ends the ring: transition to IDLE.
- Disarm: disarm[N] clears armed[N] and pending[N], and cancels the snooze if it holds N. If N is ringing, behave as stop.
- Set and disarm on the same slot in the same cycle: disarm wins.
- Match: in the tick cycle, pending[i] <= pending[i] | (armed[i] & time equal). Comparison uses slot values registered before that edge. A set in the tick cycle affects the next tick only.
- FSM states: IDLE, RING.
  - IDLE: if pending != 0, go to RING with active_id = lowest set pending index; ring counter = 0, beep phase = 1.
  - RING: each tick increments the ring counter and toggles beep phase. ring_out = RING & beep phase.
- Latency: match tick in cycle T → pending at T+1 → ring_out/ringing high at T+2.
- Exits from RING, each clearing pending[active_id] and returning to IDLE:
  - stop_btn.
  - snooze_btn: additionally load the snooze slot with id = active_id, count = SNOOZE_SECS.
  - Ring counter reaching RING_SECS: auto-stop.
- stop and snooze in the same cycle: stop wins. Both are ignored in IDLE.
- Other pending alarms stay queued and are served next, lowest index first, after one IDLE cycle. A match of the active id while ringing does not restart it.
- Snooze slot: decrements on each tick in any state. On reaching 0 it sets pending[id] and empties. A new snooze overwrites an occupied slot; the old one is dropped.
- Counter widths: $clog2(param+1). No wrap; counters saturate at the compare value.

Decomposition:
- Package alarm_pkg:
  - FSM state encoding.
  - MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59.
  - Slot-id constants 1-3; NO_ALARM=0.
- Sub-module alarm_slot, instantiated three times:
  - Storage, range check, armed flag and equality compare.
  - Outputs armed, match and load_err.
  - Top level holds the arbiter, FSM, ring and snooze counters.

Test Plan:
- Load alarm 2 = 07:30:05; clock reaches 07:30:05 with tick at T → ringing=1, active_id=2 at T+2; ring_out toggles each tick; auto-stop after 60 ticks; armed[1] stays 1.
- Alarms 1 and 3 both 12:00:00; tick → alarm 1 rings. stop → one IDLE cycle, then alarm 3 rings.
- Alarm 1 ringing; snooze at tick 3 → IDLE, snoozed=1. After 300 ticks → rings again with active_id=1.
- set3 with hour=24 → set_err pulse, armed[2] unchanged. set3 with 23:59:59 → armed[2]=1, set_err=0.
- Alarm 2 ringing; disarm[1] → ringing=0 next edge, armed[1]=0. Same-cycle stop+snooze → stop wins, snoozed=0.
- Assert rst while ringing and snoozed → all outputs 0 next edge; a subsequent matching tick does not ring (armed=0).
